// File: rtl/lsu_pkg.sv
// Shared constants for the load/store sequencer: funct3 codes and FSM encoding.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/replication, load extract/extend and
// access legality flags. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection, strobe generation and legality decode.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = '0;
    shifted    = rdata >> {addr_lo, 3'b000};
    byte_v     = shifted[7:0];
    half_v     = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    if (we) begin
      case (funct3)
        SB: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        SH: begin
          be         = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
        end
        SW:      be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end

    case (funct3)
      LB:      rdata_ext = {{24{byte_v[7]}}, byte_v};
      LH:      rdata_ext = {{16{half_v[15]}}, half_v};
      LW:      rdata_ext = rdata;
      LBU:     rdata_ext = {24'b0, byte_v};
      LHU:     rdata_ext = {16'b0, half_v};
      default: rdata_ext = '0;
    endcase

    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

    if (we) illegal = (funct3 > 3'b010);
    else    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one access at a time, runs the memory
// valid/ready handshake, waits for load data and returns a one-cycle response.
//
//  state | meaning
//  IDLE  | ready for a new access (req_ready registered, rises after reset)
//  REQ   | mem_valid asserted, waiting for mem_ready
//  WAIT  | load accepted by memory, waiting for mem_rvalid
//  RESP  | one-cycle resp_valid pulse
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        stall
);

  lsu_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       rd_q, rd_d;
  logic             err_q, err_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // While idle the aligner looks at the live request so legality is known at
  // accept; afterwards it works from the latched copy.
  logic        idle;
  logic        a_we;
  logic [2:0]  a_funct3;
  logic [1:0]  a_addr_lo;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [31:0] a_wdata_lane;
  logic [31:0] a_rdata_ext;
  logic        a_misaligned;
  logic        a_illegal;
  logic        to_hit;
  logic        in_req;

  assign idle      = (state_q == IDLE);
  assign a_we      = idle ? req_we         : we_q;
  assign a_funct3  = idle ? req_funct3     : funct3_q;
  assign a_addr_lo = idle ? req_addr[1:0]  : addr_q[1:0];
  assign a_wdata   = idle ? req_wdata      : wdata_q;

  lsu_align u_align (
    .we         (a_we),
    .funct3     (a_funct3),
    .addr_lo    (a_addr_lo),
    .wdata      (a_wdata),
    .rdata      (mem_rdata),
    .be         (a_be),
    .wdata_lane (a_wdata_lane),
    .rdata_ext  (a_rdata_ext),
    .misaligned (a_misaligned),
    .illegal    (a_illegal)
  );

  // Abort when this cycle would bring the REQ+WAIT count up to TIMEOUT.
  assign to_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

  // Next-state, request latching and timeout counting.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    err_d    = err_q;
    data_d   = data_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          data_d   = '0;
          cnt_d    = '0;
          err_d    = a_illegal || a_misaligned;
          state_d  = (a_illegal || a_misaligned) ? RESP : REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ready) begin
          state_d = we_q ? RESP : WAIT;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          data_d  = a_rdata_ext;
          state_d = RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_req     = (state_q == REQ);
  assign req_ready  = ready_q;
  assign mem_valid  = in_req;
  assign mem_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be     = in_req ? a_be                  : '0;
  assign mem_wdata  = in_req ? a_wdata_lane          : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q && !we_q) ? data_q : '0;
  assign resp_rd    = (resp_valid && !we_q) ? rd_q : '0;
  assign stall      = !idle || (req_valid && !ready_q);

endmodule
